// File: rtl/video_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// video_sequencer_pkg
// Shared definitions for the composite video sequencer: analogue level
// encodings, the horizontal line FSM state enum and the default line/field
// timing constants (in clocks of the 16x subcarrier clock).
// No ports; imported by video_timing and video_sequencer.
// ---------------------------------------------------------------------------
package video_sequencer_pkg;

    // Level code handed to the synthesizer.
    typedef enum logic [1:0] {
        LVL_SYNC   = 2'b00,
        LVL_BLANK  = 2'b01,
        LVL_BURST  = 2'b10,
        LVL_ACTIVE = 2'b11
    } level_e;

    // Horizontal line phases, in the order they occur along a line.
    typedef enum logic [2:0] {
        ST_SYNC,
        ST_BREEZE,
        ST_BURST,
        ST_BACKPORCH,
        ST_ACTIVE,
        ST_FRONTPORCH
    } hstate_e;

    localparam int          DEF_H_TOTAL      = 3640;
    localparam int          DEF_H_SYNC       = 269;
    localparam int          DEF_BURST_START  = 305;
    localparam int          DEF_BURST_LEN    = 144;
    localparam int          DEF_ACTIVE_START = 601;
    localparam int          DEF_ACTIVE_LEN   = 2992;
    localparam int          DEF_V_TOTAL      = 262;
    localparam int          DEF_V_SYNC_FIRST = 3;
    localparam int          DEF_V_SYNC_LAST  = 5;
    localparam int          DEF_PIX_DIV      = 16;
    localparam int          DEF_PHASE_INC    = 16;
    localparam logic [7:0]  DEF_BLACK        = 8'h00;

    // Level produced by each line phase on an ordinary (non vertical-sync) line.
    function automatic level_e state_level(input hstate_e s);
        case (s)
            ST_SYNC:   return LVL_SYNC;
            ST_BURST:  return LVL_BURST;
            ST_ACTIVE: return LVL_ACTIVE;
            default:   return LVL_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/video_timing.sv
// ---------------------------------------------------------------------------
// video_timing
// Line/field position counters and the horizontal line FSM. Produces the
// registered level code, which lags h_count/v_count by one clock.
//
// Ports
//   clk, reset      : clock, asynchronous active-high reset
//   enable          : counters run when high; low holds them at 0, level BLANK
//   h_count[11:0]   : position within the line
//   v_count[8:0]    : line within the field
//   level[1:0]      : registered level code for the previous h_count
//   active_next     : level about to be registered is ACTIVE (aligns pixel
//                     fetch strobes in the top with level)
//   field_wrap      : this clock moves v_count from V_TOTAL-1 to 0
// ---------------------------------------------------------------------------
module video_timing
    import video_sequencer_pkg::*;
#(
    parameter int H_TOTAL      = DEF_H_TOTAL,
    parameter int H_SYNC       = DEF_H_SYNC,
    parameter int BURST_START  = DEF_BURST_START,
    parameter int BURST_LEN    = DEF_BURST_LEN,
    parameter int ACTIVE_START = DEF_ACTIVE_START,
    parameter int ACTIVE_LEN   = DEF_ACTIVE_LEN,
    parameter int V_TOTAL      = DEF_V_TOTAL,
    parameter int V_SYNC_FIRST = DEF_V_SYNC_FIRST,
    parameter int V_SYNC_LAST  = DEF_V_SYNC_LAST
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    output logic [11:0] h_count,
    output logic [8:0]  v_count,
    output logic [1:0]  level,
    output logic        active_next,
    output logic        field_wrap
);

    localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
    localparam logic [11:0] H_SYNC_END = 12'(H_SYNC);
    localparam logic [11:0] BURST_BEG  = 12'(BURST_START);
    localparam logic [11:0] BURST_END  = 12'(BURST_START + BURST_LEN);
    localparam logic [11:0] ACT_BEG    = 12'(ACTIVE_START);
    localparam logic [11:0] ACT_END    = 12'(ACTIVE_START + ACTIVE_LEN);
    // Vertical sync lines use broad pulses: sync for the first half-line
    // minus a normal sync width.
    localparam logic [11:0] VSYNC_TIP  = 12'(H_TOTAL / 2 - H_SYNC);
    localparam logic [8:0]  V_LAST     = 9'(V_TOTAL - 1);
    localparam logic [8:0]  V_SYNC_LO  = 9'(V_SYNC_FIRST);
    localparam logic [8:0]  V_SYNC_HI  = 9'(V_SYNC_LAST);

    logic [11:0] h_count_q, h_count_d;
    logic [8:0]  v_count_q, v_count_d;
    hstate_e     state_q, state_d;
    level_e      level_q, level_d;
    logic        line_end;
    logic        vsync_line;

    always_comb begin
        line_end   = (h_count_q == H_LAST);
        field_wrap = enable && line_end && (v_count_q == V_LAST);
        vsync_line = (v_count_q >= V_SYNC_LO) && (v_count_q <= V_SYNC_HI);

        h_count_d = 12'd0;
        v_count_d = 9'd0;
        if (enable) begin
            h_count_d = line_end ? 12'd0 : h_count_q + 12'd1;
            v_count_d = v_count_q;
            if (line_end) begin
                v_count_d = (v_count_q == V_LAST) ? 9'd0 : v_count_q + 9'd1;
            end
        end

        // Line phase entered at the current h_count.
        state_d = state_q;
        if (!enable)                     state_d = ST_SYNC;
        else if (h_count_q == 12'd0)     state_d = ST_SYNC;
        else if (h_count_q == H_SYNC_END) state_d = ST_BREEZE;
        else if (h_count_q == BURST_BEG) state_d = ST_BURST;
        else if (h_count_q == BURST_END) state_d = ST_BACKPORCH;
        else if (h_count_q == ACT_BEG)   state_d = ST_ACTIVE;
        else if (h_count_q == ACT_END)   state_d = ST_FRONTPORCH;

        level_d = state_level(state_d);
        if (!enable) begin
            level_d = LVL_BLANK;
        end else if (vsync_line) begin
            level_d = (h_count_q < VSYNC_TIP) ? LVL_SYNC : LVL_BLANK;
        end

        active_next = (level_d == LVL_ACTIVE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            h_count_q <= 12'd0;
            v_count_q <= 9'd0;
            state_q   <= ST_SYNC;
            level_q   <= LVL_BLANK;
        end else begin
            h_count_q <= h_count_d;
            v_count_q <= v_count_d;
            state_q   <= state_d;
            level_q   <= level_d;
        end
    end

    assign h_count = h_count_q;
    assign v_count = v_count_q;
    assign level   = level_q;

endmodule

// File: rtl/video_sequencer.sv
// ---------------------------------------------------------------------------
// video_sequencer
// Composite video sequencer: line/field timing (video_timing), pixel fetch
// from an external pixel source, colour hold per pixel, underrun detection
// and the free-running colour subcarrier phase accumulator.
//
// Ports
//   clk             : sole clock, 16x subcarrier
//   reset           : asynchronous, active-high
//   enable          : sequencing runs when high
//   pattern_sel     : (TEST_PATTERN_EN builds only) selects colour bars
//   pix_data[7:0]   : colour number from pixel source
//   pix_valid       : pix_data valid in the pix_req cycle
//   pix_req         : one-cycle pixel fetch strobe
//   colourNum[7:0]  : colour index to synthesizer
//   phase[7:0]      : subcarrier phase
//   level[1:0]      : 00 SYNC, 01 BLANK, 10 BURST, 11 ACTIVE
//   h_count[11:0], v_count[8:0] : current position
//   underrun        : sticky missed-pixel flag, cleared at field wrap
//
// Build option: define TEST_PATTERN_EN to add pattern_sel and an internal
// eight-bar colour pattern generator.
// ---------------------------------------------------------------------------
module video_sequencer
    import video_sequencer_pkg::*;
#(
    parameter int         H_TOTAL      = DEF_H_TOTAL,
    parameter int         H_SYNC       = DEF_H_SYNC,
    parameter int         BURST_START  = DEF_BURST_START,
    parameter int         BURST_LEN    = DEF_BURST_LEN,
    parameter int         ACTIVE_START = DEF_ACTIVE_START,
    parameter int         ACTIVE_LEN   = DEF_ACTIVE_LEN,
    parameter int         V_TOTAL      = DEF_V_TOTAL,
    parameter int         V_SYNC_FIRST = DEF_V_SYNC_FIRST,
    parameter int         V_SYNC_LAST  = DEF_V_SYNC_LAST,
    parameter int         PIX_DIV      = DEF_PIX_DIV,
    parameter int         PHASE_INC    = DEF_PHASE_INC,
    parameter logic [7:0] BLACK        = DEF_BLACK
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
`ifdef TEST_PATTERN_EN
    input  logic        pattern_sel,
`endif
    input  logic [7:0]  pix_data,
    input  logic        pix_valid,
    output logic        pix_req,
    output logic [7:0]  colourNum,
    output logic [7:0]  phase,
    output logic [1:0]  level,
    output logic [11:0] h_count,
    output logic [8:0]  v_count,
    output logic        underrun
);

    localparam logic [11:0] ACT_BEG   = 12'(ACTIVE_START);
    localparam logic [11:0] PIX_DIV_C = 12'(PIX_DIV);
    localparam logic [7:0]  PHASE_STEP = 8'(PHASE_INC);
`ifdef TEST_PATTERN_EN
    localparam logic [11:0] BAR_W     = 12'(ACTIVE_LEN / 8);
`endif

    logic        active_next;
    logic        field_wrap;
    logic        pattern_on;
    logic [11:0] act_off;
    logic        fetch_slot;

    logic        pix_req_q, pix_req_d;
    logic [7:0]  colour_q, colour_d;
    logic [7:0]  phase_q, phase_d;
    logic        underrun_q, underrun_d;
`ifdef TEST_PATTERN_EN
    logic [11:0] bar_idx;
    logic [7:0]  bar_colour;
`endif

    video_timing #(
        .H_TOTAL      (H_TOTAL),
        .H_SYNC       (H_SYNC),
        .BURST_START  (BURST_START),
        .BURST_LEN    (BURST_LEN),
        .ACTIVE_START (ACTIVE_START),
        .ACTIVE_LEN   (ACTIVE_LEN),
        .V_TOTAL      (V_TOTAL),
        .V_SYNC_FIRST (V_SYNC_FIRST),
        .V_SYNC_LAST  (V_SYNC_LAST)
    ) u_timing (
        .clk         (clk),
        .reset       (reset),
        .enable      (enable),
        .h_count     (h_count),
        .v_count     (v_count),
        .level       (level),
        .active_next (active_next),
        .field_wrap  (field_wrap)
    );

`ifdef TEST_PATTERN_EN
    assign pattern_on = pattern_sel;
`else
    assign pattern_on = 1'b0;
`endif

    always_comb begin
        // Offset into the active region; only meaningful while active_next.
        act_off    = h_count - ACT_BEG;
        fetch_slot = active_next && ((act_off % PIX_DIV_C) == 12'd0);
        pix_req_d  = fetch_slot && !pattern_on;

        // Phase runs even while disabled so the subcarrier stays continuous.
        phase_d = phase_q + PHASE_STEP;

        // pix_req_q marks the cycle the source answers; the colour then holds
        // until the next fetch, and drops to black once level leaves ACTIVE.
        if (pix_req_q) begin
            colour_d = pix_valid ? pix_data : BLACK;
        end else if (level == LVL_ACTIVE) begin
            colour_d = colour_q;
        end else begin
            colour_d = BLACK;
        end

`ifdef TEST_PATTERN_EN
        bar_idx    = act_off / BAR_W;
        bar_colour = 8'(bar_idx << 3);
        if (pattern_on) begin
            colour_d = active_next ? bar_colour : BLACK;
        end
`endif

        // Set wins over the field-wrap clear.
        underrun_d = (pix_req_q && !pix_valid && !pattern_on) ||
                     (underrun_q && !field_wrap);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pix_req_q  <= 1'b0;
            colour_q   <= BLACK;
            phase_q    <= 8'd0;
            underrun_q <= 1'b0;
        end else begin
            pix_req_q  <= pix_req_d;
            colour_q   <= colour_d;
            phase_q    <= phase_d;
            underrun_q <= underrun_d;
        end
    end

    assign pix_req   = pix_req_q;
    assign colourNum = colour_q;
    assign phase     = phase_q;
    assign underrun  = underrun_q;

endmodule

// File: tb/tb_video_sequencer.sv
module tb_video_sequencer;

    localparam int H_TOTAL = 3640;
    // Shortened field (lines 0..11) so field wrap is reached in a short run;
    // vertical sync lines 3..5 and line 10 still exist.
    localparam int V_TOTAL = 12;
    localparam logic [1:0] L_SYNC   = 2'b00;
    localparam logic [1:0] L_BLANK  = 2'b01;
    localparam logic [1:0] L_BURST  = 2'b10;
    localparam logic [1:0] L_ACTIVE = 2'b11;

    logic        clk = 1'b0;
    logic        reset;
    logic        enable;
    logic [7:0]  pix_data;
    logic        pix_valid;
    logic        pix_req;
    logic [7:0]  colourNum;
    logic [7:0]  phase;
    logic [1:0]  level;
    logic [11:0] h_count;
    logic [8:0]  v_count;
    logic        underrun;

    always #5 clk = ~clk;

    video_sequencer #(.V_TOTAL(V_TOTAL)) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
`ifdef TEST_PATTERN_EN
        .pattern_sel (1'b0),
`endif
        .pix_data  (pix_data),
        .pix_valid (pix_valid),
        .pix_req   (pix_req),
        .colourNum (colourNum),
        .phase     (phase),
        .level     (level),
        .h_count   (h_count),
        .v_count   (v_count),
        .underrun  (underrun)
    );

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Phase model: clocks since reset release times 16, mod 256.
    int unsigned ncyc;
    always @(posedge clk or posedge reset) begin
        if (reset) ncyc <= 0;
        else       ncyc <= ncyc + 1;
    end
    function automatic int exp_phase();
        return int'((ncyc * 16) % 256);
    endfunction

    // Pixel source + colour scoreboard.
    logic [7:0] sb[$];
    int         req_cnt[16];
    int         bad_req   = 0;
    int         pix_total = 0;
    bit         pass1     = 1'b1;
    bit         inj2      = 1'b0;
    bit         first_seen = 1'b0;
    logic [7:0] d_sel;
    bit         v_sel;

    always @(negedge clk) begin
        if (reset) begin
            sb.delete();
            pix_valid = 1'b0;
        end else begin
            if (sb.size() > 0) chk("pixel_colour", int'(colourNum), int'(sb.pop_front()));
            pix_valid = 1'b0;
            pix_data  = 8'hFF;
            if (pix_req) begin
                if (level != L_ACTIVE) bad_req++;
                d_sel = 8'(pix_total * 37 + 11);
                v_sel = 1'b1;
                if (!first_seen) begin
                    first_seen = 1'b1;
                    d_sel = 8'h2A;
                    chk("first_req_h", int'(h_count), 602);
                end
                if (pass1 && v_count == 9'd1 && req_cnt[1] == 5) v_sel = 1'b0;
                if (inj2) begin
                    v_sel = 1'b0;
                    inj2  = 1'b0;
                end
                if (pass1 && v_count < 9'd16) req_cnt[v_count[3:0]]++;
                pix_total++;
                pix_data  = d_sel;
                pix_valid = v_sel;
                sb.push_back(v_sel ? d_sel : 8'h00);
            end
        end
    end

    // First pixel (8'h2A) must be held for 16 clocks after loading.
    always @(negedge clk) begin
        if (!reset && pass1 && v_count == 9'd0 && h_count >= 12'd603 && h_count <= 12'd618)
            chk($sformatf("hold_2A h%0d", h_count), int'(colourNum), 8'h2A);
    end

    typedef struct {
        int         v;
        int         h;
        logic [1:0] lvl;
        bit         blk;
        bit         urun;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input int v, input int h, input logic [1:0] l,
                                input bit b, input bit u);
        vec_t e;
        e.v = v; e.h = h; e.lvl = l; e.blk = b; e.urun = u;
        tbl.push_back(e);
    endfunction

    bit lost = 1'b0;
    task automatic wait_pos(input int v, input int h);
        int n = 0;
        if (lost) return;
        while (!(int'(v_count) == v && int'(h_count) == h)) begin
            if (n >= 50000) begin
                n_chk++;
                n_err++;
                $display("FAIL wait_pos: v=%0d h=%0d not reached, now v=%0d h=%0d", v, h, v_count, h_count);
                lost = 1'b1;
                return;
            end
            @(negedge clk);
            n++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_h"},        int'(h_count), 0);
        chk({tag, "_v"},        int'(v_count), 0);
        chk({tag, "_phase"},    int'(phase), 0);
        chk({tag, "_colour"},   int'(colourNum), 0);
        chk({tag, "_level"},    int'(level), int'(L_BLANK));
        chk({tag, "_pix_req"},  int'(pix_req), 0);
        chk({tag, "_underrun"}, int'(underrun), 0);
    endtask

    initial begin
        #(10 * 120000);
        $display("FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; pix_data = 8'h00; pix_valid = 1'b0;
        for (int i = 0; i < 16; i++) req_cnt[i] = 0;

        add(0, 0, L_SYNC, 1, 0);     add(0, 268, L_SYNC, 1, 0);
        add(0, 269, L_BLANK, 1, 0);  add(0, 304, L_BLANK, 1, 0);
        add(0, 305, L_BURST, 1, 0);  add(0, 448, L_BURST, 1, 0);
        add(0, 449, L_BLANK, 1, 0);  add(0, 600, L_BLANK, 1, 0);
        add(0, 601, L_ACTIVE, 0, 0); add(0, 3592, L_ACTIVE, 0, 0);
        add(0, 3593, L_BLANK, 0, 0); add(0, 3639, L_BLANK, 1, 0);
        add(4, 0, L_SYNC, 1, 1);     add(4, 305, L_SYNC, 1, 1);
        add(4, 1550, L_SYNC, 1, 1);  add(4, 1551, L_BLANK, 1, 1);
        add(4, 3000, L_BLANK, 1, 1); add(4, 3639, L_BLANK, 1, 1);
        add(10, 304, L_BLANK, 1, 1); add(10, 305, L_BURST, 1, 1);
        add(10, 448, L_BURST, 1, 1); add(10, 449, L_BLANK, 1, 1);
        add(10, 601, L_ACTIVE, 0, 1); add(10, 3592, L_ACTIVE, 0, 1);
        add(10, 3593, L_BLANK, 0, 1);

        repeat (3) @(negedge clk);
        chk_reset_vals("rst");
        enable = 1'b1;
        @(negedge clk);
        reset = 1'b0;

        for (int i = 0; i < tbl.size(); i++) begin
            vec_t e;
            e = tbl[i];
            wait_pos(e.v, e.h);
            @(negedge clk);
            chk($sformatf("level v%0d h%0d", e.v, e.h), int'(level), int'(e.lvl));
            chk($sformatf("h_count after v%0d h%0d", e.v, e.h), int'(h_count), (e.h + 1) % H_TOTAL);
            chk($sformatf("v_count after v%0d h%0d", e.v, e.h), int'(v_count),
                (e.h == H_TOTAL - 1) ? (e.v + 1) % V_TOTAL : e.v);
            chk($sformatf("phase v%0d h%0d", e.v, e.h), int'(phase), exp_phase());
            chk($sformatf("underrun v%0d h%0d", e.v, e.h), int'(underrun), int'(e.urun));
            if (e.blk) chk($sformatf("black v%0d h%0d", e.v, e.h), int'(colourNum), 0);
        end

        wait_pos(11, 0);
        chk("req_count_line0", req_cnt[0], 187);
        chk("req_count_line3", req_cnt[3], 0);
        chk("req_count_line4", req_cnt[4], 0);
        chk("req_count_line5", req_cnt[5], 0);
        chk("req_count_line10", req_cnt[10], 187);
        chk("req_outside_active", bad_req, 0);

        wait_pos(11, H_TOTAL - 1);
        chk("underrun_before_wrap", int'(underrun), 1);
        @(negedge clk);
        chk("wrap_v", int'(v_count), 0);
        chk("wrap_h", int'(h_count), 0);
        chk("underrun_after_wrap", int'(underrun), 0);
        pass1 = 1'b0;

        wait_pos(1, 500);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_h", int'(h_count), 0);
        chk("dis_v", int'(v_count), 0);
        chk("dis_level", int'(level), int'(L_BLANK));
        chk("dis_pix_req", int'(pix_req), 0);
        chk("dis_phase", int'(phase), exp_phase());
        repeat (4) @(negedge clk);
        chk("dis_hold_h", int'(h_count), 0);
        chk("dis_hold_phase", int'(phase), exp_phase());
        enable = 1'b1;
        inj2   = 1'b1;

        wait_pos(0, 1000);
        chk("underrun_second", int'(underrun), 1);
        #2 reset = 1'b1;
        #1 chk_reset_vals("async_rst");
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_phase1", int'(phase), 16);
        chk("post_rst_h", int'(h_count), 1);
        chk("post_rst_level", int'(level), int'(L_SYNC));
        @(negedge clk);
        chk("post_rst_phase2", int'(phase), 32);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
